// File: rtl/dpc_pkg.sv
// Shared constants, entry field layout and FSM state type for the DPC bad-pixel table.
package dpc_pkg;

   localparam int COORD_W    = 11;
   localparam int TABLE_BASE = 4;
   localparam int X_LSB      = 0;
   localparam int Y_LSB      = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } bp_state_e;

   // Raster key: row-major, so y is the more significant half.
   function automatic logic [2*COORD_W-1:0] entry_key(input logic [COORD_W-1:0] y,
                                                      input logic [COORD_W-1:0] x);
      return {y, x};
   endfunction

endpackage

// File: rtl/dpc_bp_ram.sv
// Bad-pixel table storage: one synchronous write port, two asynchronous read ports.
module dpc_bp_ram #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 9,
   parameter int DEPTH  = 512
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [IDX_W-1:0]  i_raddr_a,
   output logic [DATA_W-1:0] o_rdata_a,
   input  logic [IDX_W-1:0]  i_raddr_b,
   output logic [DATA_W-1:0] o_rdata_b
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Contents are deliberately not reset; software loads the table before use.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/dpc_bp_table.sv
// Bad-pixel table: absorbs LUT writes, serves read-back, streams entries per frame.
// Optional raster-order checker enabled by defining DPC_BP_ORDER_CHECK_EN.
module dpc_bp_table
   import dpc_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int LUT_INDEX_WIDTH    = 9,
   parameter int LUT_INDEX_NUM      = 512
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESETN,
   input  logic                          wen_lut,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] waddr_lut,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_lut,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] raddr_lut,
   output logic [C_S_AXI_DATA_WIDTH-1:0] rdata_lut,
   input  logic                          go,
   input  logic                          bp_table_ready,
   input  logic [LUT_INDEX_WIDTH:0]      all_bp_num,
   input  logic                          frame_start,
   output logic                          bp_valid,
   input  logic                          bp_ready,
   output logic [COORD_W-1:0]            bp_x,
   output logic [COORD_W-1:0]            bp_y,
   output logic                          frame_done,
   output logic                          busy,
   output logic                          order_err
);

   localparam int CNT_W = LUT_INDEX_WIDTH + 1;
   localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_LO  = C_S_AXI_ADDR_WIDTH'(TABLE_BASE);
   localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_HI  = C_S_AXI_ADDR_WIDTH'(TABLE_BASE + LUT_INDEX_NUM);
   localparam logic [LUT_INDEX_WIDTH-1:0]    IDX_BASE = LUT_INDEX_WIDTH'(TABLE_BASE);
   localparam logic [CNT_W-1:0]              CNT_MAX  = CNT_W'(LUT_INDEX_NUM);

   bp_state_e                     r_state;
   bp_state_e                     w_state_nxt;
   logic                          r_bp_valid, w_valid_nxt;
   logic [COORD_W-1:0]            r_bp_x, w_x_nxt;
   logic [COORD_W-1:0]            r_bp_y, w_y_nxt;
   logic [CNT_W-1:0]              r_rd_ptr, w_ptr_nxt;
   logic [CNT_W-1:0]              r_count, w_cnt_nxt;
   logic                          r_frame_done, w_done_nxt;
   logic                          r_busy;

   logic                          w_wr_en, w_rd_hit;
   logic [LUT_INDEX_WIDTH-1:0]    w_wr_idx, w_rd_idx, w_fetch_idx;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_rb_data, w_fetch_data;
   logic [COORD_W-1:0]            w_fx, w_fy;
   logic [CNT_W-1:0]              w_count_in;
   logic                          w_start_q, w_start_run, w_fresh, w_adv, w_load, w_last_acc;
   logic                          w_unused_fetch;

   // Offsetting only the low index bits is exact once the full address is known in range.
   assign w_wr_en  = wen_lut && (waddr_lut >= ADDR_LO) && (waddr_lut < ADDR_HI);
   assign w_wr_idx = waddr_lut[LUT_INDEX_WIDTH-1:0] - IDX_BASE;
   assign w_rd_hit = (raddr_lut >= ADDR_LO) && (raddr_lut < ADDR_HI);
   assign w_rd_idx = raddr_lut[LUT_INDEX_WIDTH-1:0] - IDX_BASE;

   dpc_bp_ram #(
      .DATA_W (C_S_AXI_DATA_WIDTH),
      .IDX_W  (LUT_INDEX_WIDTH),
      .DEPTH  (LUT_INDEX_NUM)
   ) u_ram (
      .i_clk     (S_AXI_ACLK),
      .i_we      (w_wr_en),
      .i_waddr   (w_wr_idx),
      .i_wdata   (wdata_lut),
      .i_raddr_a (w_rd_idx),
      .o_rdata_a (w_rb_data),
      .i_raddr_b (w_fetch_idx),
      .o_rdata_b (w_fetch_data)
   );

   assign rdata_lut = w_rd_hit ? w_rb_data : {C_S_AXI_DATA_WIDTH{1'b0}};

   assign w_count_in  = (all_bp_num > CNT_MAX) ? CNT_MAX : all_bp_num;
   assign w_start_q   = frame_start && go && bp_table_ready;
   assign w_start_run = w_start_q && (w_count_in != {CNT_W{1'b0}});
   // A fresh start presents entry 0 immediately; a restart from STREAM first drains the output.
   assign w_fresh     = w_start_run && (r_state != STREAM);
   assign w_adv       = go && !w_start_q && (r_state == STREAM)
                        && (!r_bp_valid || bp_ready) && (r_rd_ptr < r_count);
   assign w_load      = w_fresh || w_adv;
   assign w_last_acc  = (r_state == STREAM) && r_bp_valid && bp_ready && (r_rd_ptr == r_count);

   assign w_fetch_idx    = w_start_q ? {LUT_INDEX_WIDTH{1'b0}} : r_rd_ptr[LUT_INDEX_WIDTH-1:0];
   assign w_fx           = w_fetch_data[X_LSB +: COORD_W];
   assign w_fy           = w_fetch_data[Y_LSB +: COORD_W];
   assign w_unused_fetch = ^w_fetch_data;

   // State register
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; go low wins over everything
   always_comb begin
      w_state_nxt = r_state;
      if (!go) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start_run) w_state_nxt = STREAM;
               else             w_state_nxt = IDLE;
            end
            STREAM: begin
               if (w_start_run)     w_state_nxt = STREAM;
               else if (w_start_q)  w_state_nxt = IDLE;
               else if (w_last_acc) w_state_nxt = DONE;
               else                 w_state_nxt = STREAM;
            end
            DONE: begin
               if (w_start_run)    w_state_nxt = STREAM;
               else if (w_start_q) w_state_nxt = IDLE;
               else                w_state_nxt = DONE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Output-register next values
   always_comb begin
      w_x_nxt     = r_bp_x;
      w_y_nxt     = r_bp_y;
      w_ptr_nxt   = r_rd_ptr;
      w_valid_nxt = r_bp_valid;
      w_cnt_nxt   = r_count;
      w_done_nxt  = 1'b0;
      if (w_load) begin
         w_x_nxt   = w_fx;
         w_y_nxt   = w_fy;
         w_ptr_nxt = CNT_W'(w_fetch_idx) + CNT_W'(1);
      end else if (w_start_q) begin
         w_ptr_nxt = {CNT_W{1'b0}};
      end else begin
         w_ptr_nxt = r_rd_ptr;
      end
      if (!go) begin
         w_valid_nxt = 1'b0;
      end else if (w_start_q) begin
         w_valid_nxt = w_load;
         w_cnt_nxt   = w_count_in;
         w_done_nxt  = !w_start_run;
      end else if (w_last_acc) begin
         w_valid_nxt = 1'b0;
         w_done_nxt  = 1'b1;
      end else if (r_state == STREAM) begin
         w_valid_nxt = r_bp_valid || w_load;
      end else begin
         w_valid_nxt = 1'b0;
      end
   end

   // Output and pointer registers
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_bp_valid   <= 1'b0;
         r_bp_x       <= {COORD_W{1'b0}};
         r_bp_y       <= {COORD_W{1'b0}};
         r_rd_ptr     <= {CNT_W{1'b0}};
         r_count      <= {CNT_W{1'b0}};
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_bp_valid   <= w_valid_nxt;
         r_bp_x       <= w_x_nxt;
         r_bp_y       <= w_y_nxt;
         r_rd_ptr     <= w_ptr_nxt;
         r_count      <= w_cnt_nxt;
         r_frame_done <= w_done_nxt;
         r_busy       <= (w_state_nxt == STREAM);
      end
   end

   assign bp_valid   = r_bp_valid;
   assign bp_x       = r_bp_x;
   assign bp_y       = r_bp_y;
   assign frame_done = r_frame_done;
   assign busy       = r_busy;

`ifdef DPC_BP_ORDER_CHECK_EN
   logic [2*COORD_W-1:0] r_prev_key;
   logic [2*COORD_W-1:0] w_key;
   logic                 r_have_prev;
   logic                 r_order_err;

   assign w_key = entry_key(w_fy, w_fx);

   // Sticky raster-order monitor over the entries loaded in the current frame
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_prev_key  <= {(2*COORD_W){1'b0}};
         r_have_prev <= 1'b0;
         r_order_err <= 1'b0;
      end else if (w_start_q) begin
         r_order_err <= 1'b0;
         r_have_prev <= w_load;
         r_prev_key  <= w_key;
      end else if (w_load) begin
         if (r_have_prev && (w_key <= r_prev_key)) begin
            r_order_err <= 1'b1;
         end
         r_prev_key  <= w_key;
         r_have_prev <= 1'b1;
      end
   end

   assign order_err = r_order_err;
`else
   assign order_err = 1'b0;
`endif

endmodule
